// File: rtl/nebula_pkg.sv
// nebula_pkg: shared types and helpers for the data-side memory arbiter.
// Imported by nebula_mem_arbiter.
package nebula_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWNER_D,
        OWNER_PTW
    } arb_owner_e;

    function automatic int offset_bits(input int width);
        return $clog2(width / 8);
    endfunction

    localparam int LINE_OFFSET_BITS = offset_bits(512);

endpackage

// File: rtl/nebula_mem_arbiter.sv
// nebula_mem_arbiter: round-robin D-cache / PTW arbiter onto one
// line-wide request/ack memory port, with registered responses.
module nebula_mem_arbiter
    import nebula_pkg::*;
#(
    parameter int PADDR_WIDTH = 56,
    parameter int LINE_WIDTH  = 512,
    parameter int PTW_WIDTH   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [PADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0]  d_wdata,
    output logic                   d_ack,
    output logic [LINE_WIDTH-1:0]  d_rdata,
    output logic                   d_error,
    input  logic                   p_req,
    input  logic [PADDR_WIDTH-1:0] p_addr,
    output logic                   p_ack,
    output logic [PTW_WIDTH-1:0]   p_data,
    output logic                   p_error,
    output logic                   m_req,
    output logic                   m_we,
    output logic [PADDR_WIDTH-1:0] m_addr,
    output logic [LINE_WIDTH-1:0]  m_wdata,
    input  logic                   m_ack,
    input  logic [LINE_WIDTH-1:0]  m_rdata,
    input  logic                   m_error
);

    localparam int OFF_BITS  = offset_bits(LINE_WIDTH);
    localparam int WORD_BITS = offset_bits(PTW_WIDTH);
    localparam int IDX_BITS  = OFF_BITS - WORD_BITS;

    arb_state_e             state_q, state_d;
    arb_owner_e             owner_q, owner_d;
    arb_owner_e             last_q, last_d;
    logic                   we_q, we_d;
    logic [PADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0]  wdata_q, wdata_d;
    logic [IDX_BITS-1:0]    idx_q, idx_d;
    logic [LINE_WIDTH-1:0]  d_rdata_q, d_rdata_d;
    logic [PTW_WIDTH-1:0]   p_data_q, p_data_d;
    logic                   d_err_q, d_err_d;
    logic                   p_err_q, p_err_d;
    logic                   grant_dc;

    // On a tie the D-cache wins only if the PTW was granted last.
    assign grant_dc = d_req && (!p_req || last_q == OWNER_PTW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWNER_D;
            last_q    <= OWNER_PTW;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            d_rdata_q <= '0;
            p_data_q  <= '0;
            d_err_q   <= 1'b0;
            p_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            d_rdata_q <= d_rdata_d;
            p_data_q  <= p_data_d;
            d_err_q   <= d_err_d;
            p_err_q   <= p_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        d_rdata_d = d_rdata_q;
        p_data_d  = p_data_q;
        d_err_d   = d_err_q;
        p_err_d   = p_err_q;
        unique case (state_q)
            IDLE: begin
                if (grant_dc) begin
                    state_d = BUSY;
                    owner_d = OWNER_D;
                    last_d  = OWNER_D;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                end else if (p_req) begin
                    state_d = BUSY;
                    owner_d = OWNER_PTW;
                    last_d  = OWNER_PTW;
                    we_d    = 1'b0;
                    addr_d  = {p_addr[PADDR_WIDTH-1:OFF_BITS],
                               {OFF_BITS{1'b0}}};
                    wdata_d = '0;
                    idx_d   = p_addr[OFF_BITS-1:WORD_BITS];
                end
            end
            BUSY: begin
                if (m_ack) begin
                    state_d = RESP;
                    if (owner_q == OWNER_D) begin
                        d_rdata_d = m_rdata;
                        d_err_d   = m_error;
                    end else begin
                        p_data_d = m_rdata[idx_q * PTW_WIDTH +: PTW_WIDTH];
                        p_err_d  = m_error;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_req   = (state_q == BUSY);
        m_we    = we_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        d_ack   = (state_q == RESP) && (owner_q == OWNER_D);
        p_ack   = (state_q == RESP) && (owner_q == OWNER_PTW);
        d_rdata = d_rdata_q;
        d_error = d_err_q;
        p_data  = p_data_q;
        p_error = p_err_q;
    end

endmodule

// File: tb/tb_nebula_mem_arbiter.sv
// tb_nebula_mem_arbiter: directed and randomized checks of the arbiter
// against a transaction-level round-robin model.
module tb_nebula_mem_arbiter;

    localparam int PW  = 56;
    localparam int LW  = 512;
    localparam int PTW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [PW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [LW-1:0] d_rdata;
    logic          d_error;
    logic          p_req = 1'b0;
    logic [PW-1:0] p_addr = '0;
    logic          p_ack;
    logic [PTW-1:0] p_data;
    logic          p_error;
    logic          m_req;
    logic          m_we;
    logic [PW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    logic          m_ack = 1'b0;
    logic [LW-1:0] m_rdata = '0;
    logic          m_error = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    nebula_mem_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .d_error (d_error),
        .p_req   (p_req),
        .p_addr  (p_addr),
        .p_ack   (p_ack),
        .p_data  (p_data),
        .p_error (p_error),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_rdata (m_rdata),
        .m_error (m_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [PW-1:0] rand_addr();
        return PW'({$urandom, $urandom});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        d_req = 1'b0;
        p_req = 1'b0;
        m_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Acts as the downstream port for one transaction and checks the
    // winner's request fields, response and single-cycle ack.
    task automatic serve(input bit exp_d, input int lat,
                         input logic [LW-1:0] line, input bit err,
                         input bit chk_lat);
        int n;
        bit seen;
        int idx;
        logic [PW-1:0] ea;
        logic [PTW-1:0] ep;
        n = 0;
        seen = 1'b0;
        ep = '0;
        while (!seen && n < 12) begin
            @(negedge clk);
            n++;
            seen = m_req;
        end
        chk("m_req_rise", LW'(seen), LW'(1));
        if (!seen) return;
        ea = exp_d ? d_addr : (p_addr / 64) * 64;
        chk("m_we", LW'(m_we), LW'(exp_d ? d_we : 1'b0));
        chk("m_addr", LW'(m_addr), LW'(ea));
        chk("m_wdata", m_wdata, exp_d ? d_wdata : '0);
        repeat (lat) begin
            @(negedge clk);
            n++;
        end
        chk("m_req_hold", LW'(m_req), LW'(1));
        m_ack   = 1'b1;
        m_rdata = line;
        m_error = err;
        @(negedge clk);
        n++;
        m_ack   = 1'b0;
        m_rdata = rand_line();
        m_error = ~err;
        chk("d_ack", LW'(d_ack), LW'(exp_d));
        chk("p_ack", LW'(p_ack), LW'(!exp_d));
        chk("m_req_low", LW'(m_req), LW'(0));
        if (exp_d) begin
            chk("d_rdata", d_rdata, line);
            chk("d_error", LW'(d_error), LW'(err));
        end else begin
            idx = int'(p_addr % 64) / 8;
            ep  = PTW'(line >> (idx * 64));
            chk("p_data", LW'(p_data), LW'(ep));
            chk("p_error", LW'(p_error), LW'(err));
        end
        if (chk_lat) chk("req_to_ack", LW'(n), LW'(lat + 2));
        if (exp_d) d_req = 1'b0;
        else p_req = 1'b0;
        @(negedge clk);
        chk("ack_pulse", LW'({d_ack, p_ack}), LW'(2'b00));
        if (exp_d) chk("d_rdata_hold", d_rdata, line);
        else chk("p_data_hold", LW'(p_data), LW'(ep));
    endtask

    logic [LW-1:0] line_a;
    logic [LW-1:0] line_w;
    logic [LW-1:0] wdat_b;
    bit last_d;
    bit win_d;
    int wait_n;

    initial begin
        // Reset state
        #3 rst_n = 1'b0;
        #1;
        chk("rst_m_req", LW'(m_req), LW'(0));
        chk("rst_acks", LW'({d_ack, p_ack, d_error, p_error}), LW'(0));
        chk("rst_data", d_rdata | LW'(p_data) | m_wdata, '0);
        chk("rst_m_addr", LW'({m_we, m_addr}), LW'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // D read alone
        line_a = {16{32'hA5C3_0F96}};
        d_we   = 1'b0;
        d_addr = PW'(64'h8000_0040);
        d_req  = 1'b1;
        serve(1'b1, 4, line_a, 1'b0, 1'b1);

        // PTW read, word i of the line = i * 0x1111
        for (int i = 0; i < 8; i++) line_w[i*64 +: 64] = 64'(i * 32'h1111);
        p_addr = PW'(64'h8000_1018);
        p_req  = 1'b1;
        serve(1'b0, 2, line_w, 1'b0, 1'b1);
        chk("p_data_const", LW'(p_data), LW'(64'h3333));

        // D write with error
        wdat_b  = rand_line();
        d_we    = 1'b1;
        d_wdata = wdat_b;
        d_addr  = PW'(64'h8000_2000);
        d_req   = 1'b1;
        serve(1'b1, 1, rand_line(), 1'b1, 1'b1);

        // Stray ack in IDLE
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        chk("stray_ack", LW'({d_ack, p_ack, m_req}), LW'(0));
        @(negedge clk);
        chk("stray_ack2", LW'({d_ack, p_ack, m_req}), LW'(0));
        d_we   = 1'b0;
        d_addr = rand_addr();
        d_req  = 1'b1;
        serve(1'b1, 0, rand_line(), 1'b0, 1'b1);

        // Reset mid-BUSY
        d_addr = rand_addr();
        d_req  = 1'b1;
        wait_n = 0;
        while (!m_req && wait_n < 12) begin
            @(negedge clk);
            wait_n++;
        end
        chk("busy_seen", LW'(m_req), LW'(1));
        rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        chk("arst_m_req", LW'({m_req, m_we, d_ack, p_ack}), LW'(0));
        chk("arst_err", LW'({d_error, p_error}), LW'(0));
        chk("arst_data", d_rdata | LW'(p_data) | m_wdata, '0);
        chk("arst_m_addr", LW'(m_addr), LW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Contended rounds after reset: D, P, D, P, D
        d_we    = 1'b0;
        d_addr  = rand_addr();
        p_addr  = rand_addr();
        d_req   = 1'b1;
        p_req   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            serve(k % 2 == 0, 1, rand_line(), 1'(k % 2), k == 0);
            if (k % 2 == 0) d_req = 1'b1;
            else p_req = 1'b1;
        end

        // Randomized traffic against a round-robin model
        do_reset();
        last_d = 1'b0;
        for (int r = 0; r < 30; r++) begin
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = rand_addr();
                d_wdata = rand_line();
            end
            if (!p_req && $urandom_range(0, 1) == 1) begin
                p_req  = 1'b1;
                p_addr = rand_addr();
            end
            if (!d_req && !p_req) begin
                d_req   = 1'b1;
                d_we    = 1'b0;
                d_addr  = rand_addr();
                d_wdata = rand_line();
            end
            win_d = d_req && (!p_req || !last_d);
            serve(win_d, int'($urandom_range(0, 3)), rand_line(),
                  1'($urandom_range(0, 1)), 1'b0);
            last_d = win_d;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nebula_mem_arbiter.md
# nebula_mem_arbiter

Two-to-one memory-port arbiter between the core's D-cache refill/writeback port plus its page-table-walker (PTW) port, and the single data-side memory port of the AXI adapter. It serialises D-cache line transactions and PTW 64-bit reads onto one line-wide request/ack channel. It uses round-robin arbitration and a registered response path. This lets MMU-enabled configurations run without the PTW port being tied off.

## Interface
- PADDR_WIDTH, 56, physical address width
- LINE_WIDTH, 512, cache line / downstream data width in bits
- PTW_WIDTH, 64, PTW data width; LINE_WIDTH must be a multiple of it
- clk  in  1  core clock
- rst_n  in  1  one clock; reset is asynchronous and active-low
- d_req  in  1  D-cache request, level, held until d_ack
- d_we  in  1  1 = line write, 0 = line read
- d_addr  in  PADDR_WIDTH  line address
- d_wdata  in  LINE_WIDTH  write line
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  LINE_WIDTH  read line, valid with d_ack
- d_error  out  1  error, valid with d_ack
- p_req  in  1  PTW read request, level, held until p_ack
- p_addr  in  PADDR_WIDTH  byte address of a 64-bit PTE
- p_ack  out  1  one-cycle completion pulse
- p_data  out  PTW_WIDTH  PTE, valid with p_ack
- p_error  out  1  error, valid with p_ack
- m_req  out  1  downstream request, held until m_ack
- m_we  out  1  downstream write enable
- m_addr  out  PADDR_WIDTH  downstream line-aligned address
- m_wdata  out  LINE_WIDTH  downstream write line
- m_ack  in  1  downstream completion pulse
- m_rdata  in  LINE_WIDTH  downstream read line, valid with m_ack
- m_error  in  1  downstream error, valid with m_ack

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - Sample d_req and p_req.
  - If only one is asserted, grant it.
  - If both are asserted, grant the owner that was not granted last (last_owner).
  - last_owner resets to PTW, so the D-cache wins the first tie.
  - On a grant, register owner, m_we, m_addr and m_wdata, update last_owner, and go to BUSY.
- **Downstream request contents**
  - D grant: m_we=d_we, m_addr=d_addr, m_wdata=d_wdata.
  - PTW grant: m_we=0, m_addr=p_addr with low log2(LINE_WIDTH/8) bits cleared, m_wdata=0.
  - The word index p_addr[log2(LINE_WIDTH/8)-1:log2(PTW_WIDTH/8)] is registered.
- **BUSY**
  - m_req=1 and the m_* fields are stable.
  - On m_ack, capture the response into the owner's output registers:
    - D owner: m_rdata goes to d_rdata.
    - PTW owner: m_rdata[idx*PTW_WIDTH +: PTW_WIDTH] goes to p_data.
    - m_error goes to the owner's error register.
  - Then go to RESP, with m_req low from RESP onward.
- **RESP**: pulse the owner's ack for one cycle, then go to IDLE unconditionally.
- m_ack outside BUSY is ignored.
- d_rdata, p_data and the error outputs hold their last captured value between acks.
- The error outputs are meaningful only with their ack.
- Requester dropping req mid-service is a protocol violation; the transaction still completes and the ack still pulses.

## Timing
- Reset values: all outputs 0; state IDLE; last_owner=PTW.
- Reset mid-transaction abandons the transaction; the downstream block shares rst_n.
- Latency for a single request:
  - Request seen in IDLE at edge n gives m_req=1 from cycle n+1.
  - m_ack in cycle k gives owner ack in cycle k+1.
  - Minimum with m_ack in the first BUSY cycle: req to ack = 3 cycles.
- Requesters deassert req on the edge after seeing ack. The mandatory IDLE cycle after RESP guarantees no re-grant of a stale request.
- Back-to-back throughput: one transaction per (downstream latency + 2) cycles.
- Simultaneous requests alternate strictly: D, P, D, P...
- A new request arriving during BUSY/RESP waits and is evaluated in the next IDLE.
- No combinational path from any input to any output.

## Structure
- In nebula_pkg:
  - arb_state_e {IDLE, BUSY, RESP}
  - arb_owner_e {OWNER_D, OWNER_PTW}
  - localparam LINE_OFFSET_BITS
- Single module, no sub-module; PTE word select is an inline indexed part-select.
- Instantiated between nebula_core and nebula_axi_adapter in the AXI top wrapper. It replaces the PTW tie-off there.

## Test plan
- **D read alone:** d_req=1, d_addr=0x8000_0040, downstream acks after 4 cycles with rdata pattern A → m_addr=0x8000_0040, m_we=0; d_ack pulses once with d_rdata=A; p_ack stays 0.
- **PTW read:** p_addr=0x8000_1018, line rdata with word i = i×0x1111 → m_addr=0x8000_1000, m_we=0; p_data=0x3333.
- **Simultaneous requests after reset:** d_req=p_req=1, both held → D served first, then PTW. Three further contended rounds alternate D, P, D.
- **D write with error:** d_we=1, d_wdata=B, m_error=1 with m_ack → m_wdata=B, m_we=1; d_ack and d_error high together for one cycle.
- **Reset mid-BUSY:** assert rst_n=0 while m_req=1 → all outputs 0 immediately (async). After release, a new d_req completes normally.
- **Stray ack:** m_ack pulsed in IDLE → no ack output and no state change.
